// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF/ID queue and decode-side consumers:
// MIPS instruction field positions, the NOP encoding and the queue entry type.
package if_id_queue_pkg;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_instr_field_split.sv
// Combinational split of a 32-bit MIPS instruction word into its fields.
// Shared with the decoder so both agree on field positions.
module instr_field_split
    import if_id_queue_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16
);

    assign opcode = instr[OPC_HI:OPC_LO];
    assign rs     = instr[RS_HI:RS_LO];
    assign rt     = instr[RT_HI:RT_LO];
    assign rd     = instr[RD_HI:RD_LO];
    assign shamt  = instr[SHAMT_HI:SHAMT_LO];
    assign funct  = instr[FUNCT_HI:FUNCT_LO];
    assign imm16  = instr[IMM_HI:IMM_LO];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction FIFO with flush; presents the head pre-split
// into MIPS fields and shows a NOP bubble with pc 0 when empty.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc_plus4,
    output logic [31:0]      out_instr,
    output logic [5:0]       out_opcode,
    output logic [4:0]       out_rs,
    output logic [4:0]       out_rt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_shamt,
    output logic [5:0]       out_funct,
    output logic [15:0]      out_imm16,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    if_id_entry_t     mem_q [DEPTH];
    if_id_entry_t     mem_d [DEPTH];
    if_id_entry_t     head;
    logic             push, pop;

    // in_ready depends only on occupancy, never on out_ready
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: in_pc, instr: in_instr};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed when count_q != 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head         = mem_q[rd_ptr_q];
    assign out_pc       = out_valid ? head.pc : '0;
    assign out_pc_plus4 = out_valid ? (head.pc + 32'd4) : '0;
    assign out_instr    = out_valid ? head.instr : NOP_INSTR;
    assign count        = count_q;

    instr_field_split u_split (
        .instr  (out_instr),
        .opcode (out_opcode),
        .rs     (out_rs),
        .rt     (out_rt),
        .rd     (out_rd),
        .shamt  (out_shamt),
        .funct  (out_funct),
        .imm16  (out_imm16)
    );

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed table, streaming/wrap sequences and random
// traffic, all checked against a queue-based reference model.
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_pc = '0;
    logic [31:0]      in_instr = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_pc, out_pc_plus4, out_instr;
    logic [5:0]       out_opcode, out_funct;
    logic [4:0]       out_rs, out_rt, out_rd, out_shamt;
    logic [15:0]      out_imm16;
    logic [PTR_W:0]   count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic        r, f, iv, ordy;
        logic [31:0] pc, instr;
        int          ecnt;
        logic        erdy, evld;
        logic [31:0] epc, einstr;
    } vec_t;
    vec_t tbl[15];

    if_id_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Whole-output comparison against the model queue.
    task automatic check_model();
        logic [31:0] ei, ep;
        logic        ev;
        ev = (mq.size() != 0);
        ep = ev ? mq[0].pc : 32'h0;
        ei = ev ? mq[0].instr : 32'h0;
        chk("count",     32'(count),        32'(mq.size()));
        chk("in_ready",  32'(in_ready),     32'(mq.size() < DEPTH));
        chk("out_valid", 32'(out_valid),    32'(ev));
        chk("out_pc",    out_pc,            ep);
        chk("pc_plus4",  out_pc_plus4,      ev ? ep + 32'd4 : 32'h0);
        chk("out_instr", out_instr,         ei);
        chk("opcode",    32'(out_opcode),   32'(ei[31:26]));
        chk("rs",        32'(out_rs),       32'(ei[25:21]));
        chk("rt",        32'(out_rt),       32'(ei[20:16]));
        chk("rd",        32'(out_rd),       32'(ei[15:11]));
        chk("shamt",     32'(out_shamt),    32'(ei[10:6]));
        chk("funct",     32'(out_funct),    32'(ei[5:0]));
        chk("imm16",     32'(out_imm16),    32'(ei[15:0]));
    endtask

    // Drive one cycle of inputs, clock it, and advance the model.
    task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                        input logic [31:0] pc, input logic [31:0] instr);
        bit do_push, do_pop;
        rst = r; flush = f; in_valid = iv; out_ready = ordy; in_pc = pc; in_instr = instr;
        do_push = iv && (mq.size() < DEPTH) && !f;
        do_pop  = (mq.size() != 0) && ordy && !f;
        @(posedge clk);
        #1;
        if (r || f) mq.delete();
        else begin
            if (do_pop) mq.delete(0);
            if (do_push) mq.push_back('{pc: pc, instr: instr});
        end
    endtask

    function automatic vec_t mkv(logic r, logic f, logic iv, logic ordy,
                                 logic [31:0] pc, logic [31:0] instr, int ecnt,
                                 logic erdy, logic evld, logic [31:0] epc, logic [31:0] einstr);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.ordy = ordy; v.pc = pc; v.instr = instr;
        v.ecnt = ecnt; v.erdy = erdy; v.evld = evld; v.epc = epc; v.einstr = einstr;
        return v;
    endfunction

    initial begin
        logic [31:0] pc_a, pc_b, pc_c, pc_d, pc_e, pc_f;
        logic [31:0] in_a, in_b, in_c, in_d, in_e, in_f;
        logic [31:0] p;
        bit          wrap_seen;
        pc_a = 32'h0000_1000; in_a = 32'h0109_5020;
        pc_b = 32'h0000_1004; in_b = 32'h8D28_0004;
        pc_c = 32'h0000_1008; in_c = 32'h1509_FFFE;
        pc_d = 32'h0000_2000; in_d = 32'h3C01_1234;
        pc_e = 32'h0000_2004; in_e = 32'h0000_4080;
        pc_f = 32'h0000_2008; in_f = 32'hDEAD_BEEF;

        //           r     f     iv    ordy  pc            instr         cnt rdy   vld   epc           einstr
        tbl[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0);
        tbl[1]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0);
        tbl[2]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0);
        tbl[3]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'h2008_FFFF, 1, 1'b1, 1'b1, 32'h0040_0000, 32'h2008_FFFF);
        tbl[4]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0);
        tbl[5]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, pc_a,         in_a,         1, 1'b1, 1'b1, pc_a,         in_a);
        tbl[6]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, pc_b,         in_b,         2, 1'b0, 1'b1, pc_a,         in_a);
        tbl[7]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, pc_c,         in_c,         2, 1'b0, 1'b1, pc_a,         in_a);
        tbl[8]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, pc_c,         in_c,         1, 1'b1, 1'b1, pc_b,         in_b);
        tbl[9]  = mkv(1'b0, 1'b0, 1'b1, 1'b1, pc_c,         in_c,         1, 1'b1, 1'b1, pc_c,         in_c);
        tbl[10] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0);
        tbl[11] = mkv(1'b0, 1'b0, 1'b1, 1'b0, pc_d,         in_d,         1, 1'b1, 1'b1, pc_d,         in_d);
        tbl[12] = mkv(1'b0, 1'b0, 1'b1, 1'b0, pc_e,         in_e,         2, 1'b0, 1'b1, pc_d,         in_d);
        tbl[13] = mkv(1'b0, 1'b1, 1'b1, 1'b1, pc_f,         in_f,         0, 1'b1, 1'b0, 32'h0,        32'h0);
        tbl[14] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        0, 1'b1, 1'b0, 32'h0,        32'h0);

        // Directed table: reset, single pass, backpressure, flush.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].ordy, tbl[i].pc, tbl[i].instr);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].erdy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].evld));
            chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].epc);
            chk($sformatf("tbl%0d_out_instr", i), out_instr, tbl[i].einstr);
            check_model();
        end
        // Single-pass field decode of addi $t0,$zero,-1.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'h2008_FFFF);
        chk("sp_opcode", 32'(out_opcode), 32'h08);
        chk("sp_rt", 32'(out_rt), 32'd8);
        chk("sp_imm16", 32'(out_imm16), 32'hFFFF);
        chk("sp_pc_plus4", out_pc_plus4, 32'h0040_0004);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        chk("sp_drained", 32'(out_valid), 32'd0);

        // Steady streaming: occupancy stays at 1, outputs trail inputs by a cycle.
        for (int i = 0; i < 10; i++) begin
            p = 32'h0000_3000 + 32'(i * 4);
            step(1'b0, 1'b0, 1'b1, 1'b1, p, $urandom);
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_pc", out_pc, p);
            check_model();
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        check_model();

        // Wrap-around alternating 1 <-> 2, including a head pc of 0xFFFF_FFFC.
        wrap_seen = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, $urandom);
        check_model();
        for (int i = 0; i < 9; i++) begin
            p = (i == 2) ? 32'hFFFF_FFFC : 32'h0000_5000 + 32'(i * 4);
            step(1'b0, 1'b0, 1'b1, 1'b0, p, $urandom);
            chk("wrap_count2", 32'(count), 32'd2);
            check_model();
            step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
            chk("wrap_count1", 32'(count), 32'd1);
            check_model();
            if (mq.size() != 0 && mq[0].pc == 32'hFFFF_FFFC) begin
                wrap_seen = 1'b1;
                chk("pc_plus4_wrap", out_pc_plus4, 32'h0000_0000);
            end
        end
        chk("wrap_head_seen", 32'(wrap_seen), 32'd1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 6),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Small instruction queue between instruction fetch and decode in the pipelined MIPS core.
- Buffers fetched {pc, instr} pairs with a valid/ready handshake on both sides.
- Presents the head instruction to decode pre-split into MIPS fields. Its imm16 field is the 16-bit input of the downstream immediate sign-extension unit.
- Supports pipeline flush on branch/jump redirect, and injects NOP bubbles when empty.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- PTR_W, 1, pointer width = log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  discard all queued and incoming instructions this cycle
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept; high iff count < DEPTH
- in_pc  input  32  PC of the fetched instruction
- in_instr  input  32  fetched instruction word
- out_valid  output  1  head entry valid (count != 0)
- out_ready  input  1  decode consumes the head this cycle
- out_pc  output  32  head PC (0 when empty)
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32 (0 when empty)
- out_instr  output  32  head instruction (32'h0000_0000, i.e. sll $0,$0,0 NOP, when empty)
- out_opcode  output  6  out_instr[31:26]
- out_rs  output  5  out_instr[25:21]
- out_rt  output  5  out_instr[20:16]
- out_rd  output  5  out_instr[15:11]
- out_shamt  output  5  out_instr[10:6]
- out_funct  output  6  out_instr[5:0]
- out_imm16  output  16  out_instr[15:0], fed to sign extension
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at clk edge): wr_ptr=rd_ptr=0, count=0.
  - After reset: out_valid=0, in_ready=1, and all out_* data fields read as 0.
  - Storage contents are don't-care.
- Push:
  - Occurs when in_valid && in_ready && !flush.
  - Writes {in_pc, in_instr} at wr_ptr; wr_ptr increments and wraps DEPTH-1 -> 0.
- Pop:
  - Occurs when out_valid && out_ready && !flush.
  - rd_ptr increments and wraps.
- Count update:
  - Push only: +1. Pop only: -1. Both or neither: unchanged.
- Full / empty boundaries:
  - Full (count=DEPTH): in_ready=0 regardless of out_ready, so there is no combinational ready path from decode to fetch. Fetch must hold in_pc/in_instr stable while stalled.
  - Empty: a push is not visible at the output until the next cycle. There is no bypass; latency in -> out is 1 cycle minimum.
  - out_ready while empty is ignored.
- Output data:
  - out_* data fields are driven combinationally from the storage entry at rd_ptr.
  - When count=0 they are forced to 0, so decode sees a NOP bubble with pc 0.
- Flush:
  - Highest priority after rst.
  - On the flush edge: wr_ptr=rd_ptr=0, count=0; any simultaneous push and pop are discarded.
  - in_ready stays combinational on count, so it may be 1 during the flush cycle; the push is still dropped.
  - The next cycle is empty.
- Simultaneous flush and rst: rst wins (identical result).
- Reset asserted mid-stream: the queue empties on that edge, and queued data is never presented again.
- Ordering: strict FIFO; every pushed pair is popped exactly once unless flushed.

Decomposition:
- Shared package holds:
  - MIPS field position constants (OPC_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SHAMT_HI/LO, FUNCT_HI/LO, IMM_HI/LO).
  - NOP_INSTR = 32'h0000_0000.
  - A struct/typedef for a queue entry {pc[31:0], instr[31:0]}.
- One natural sub-module: instr_field_split. It is combinational and maps a 32-bit instruction to opcode/rs/rt/rd/shamt/funct/imm16. It is reused later by the decoder.
- Storage, pointers and count stay in if_id_queue.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then 0.
  - Response: count=0, out_valid=0, in_ready=1, out_instr=0, out_imm16=0.
- Single pass:
  - Stimulus: push pc=0x0040_0000, instr=0x2008_FFFF (addi $t0,$zero,-1), out_ready=1.
  - Response: next cycle out_valid=1, out_opcode=0x08, out_rt=8, out_imm16=0xFFFF, out_pc_plus4=0x0040_0004; the cycle after, out_valid=0.
- Fill and backpressure:
  - Stimulus: out_ready=0, push 3 consecutive instructions (A, B, C).
  - Response: A and B accepted; count=2; in_ready=0 while C is held. Then raise out_ready: A, B, C pop in order, and C is accepted on the cycle after count drops to 1.
- Steady streaming:
  - Stimulus: in_valid=1, out_ready=1 for 10 cycles with incrementing pcs.
  - Response: count stays 1 after the first cycle, and outputs appear 1 cycle behind inputs with no gaps.
- Flush with concurrent push/pop:
  - Stimulus: count=2, assert flush with in_valid=1 and out_ready=1.
  - Response: next cycle count=0, out_valid=0, and the pushed instruction never appears.
- Wrap-around:
  - Stimulus: 9 push/pop sequences alternating count 1<->2.
  - Response: the data sequence exactly matches push order across pointer wrap, and out_pc_plus4 of 0xFFFF_FFFC reads 0x0000_0000.
